// File: rtl/perfect_sched.sv
// perfect_sched: round-robin front end for a single perfect-number checker
// engine. One requester at a time is granted; the scheduler loads its
// operand, runs the engine go/over handshake to completion and back to idle,
// then pulses ack to the granted requester with the captured verdict.
//
// Reset i_rst is asynchronous and active-low.
// Optional watchdog: define PERFECT_SCHED_TIMEOUT_EN to abort jobs whose
// engine never finishes (or never releases) within TIMEOUT cycles.
module perfect_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 14,
  parameter int TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_req_num,
  output logic [NREQ-1:0]   o_ack,
  output logic              o_res_perfect,
  output logic              o_res_err,
  output logic [2:0]        o_res_id,
  output logic              o_busy,
  output logic [W-1:0]      o_eng_num,
  output logic              o_eng_go,
  input  logic              i_eng_display,
  input  logic              i_eng_over
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_ptr;
  logic [2:0]      r_id;
  logic            r_verdict;

  logic [W-1:0]    w_num_arr [NREQ];
  logic            w_grant_vld;
  logic [2:0]      w_grant_id;
  logic [W-1:0]    w_grant_num;
  int              w_dist;
  int              w_best;
  logic [NREQ-1:0] w_ack_nxt;
  logic            w_wd_hit;
  logic            w_abort;

  // Unpack the flat operand bus into one word per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_num_arr[g] = i_req_num[g*W +: W];
  end

  // Round-robin pick: the requester closest above r_ptr (wrapping) wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_grant_num = '0;
    w_dist      = 0;
    w_best      = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      // distance 0 means slot r_ptr+1, the highest-priority position
      w_dist = (j + NREQ - 1 - int'(r_ptr)) % NREQ;
      if (i_req[j[IW-1:0]] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_grant_vld = 1'b1;
        w_grant_id  = 3'(j);
        w_grant_num = w_num_arr[j[IW-1:0]];
      end
    end
  end

  // One-hot acknowledge pattern for the job currently in flight.
  always_comb begin
    w_ack_nxt = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_ack_nxt[j[IW-1:0]] = (r_id == 3'(j));
    end
  end

`ifdef PERFECT_SCHED_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT - 1);

  logic [12:0] r_wd_cnt;

  // Watchdog: restarts for every job in LOAD, counts engine wait cycles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
      r_wd_cnt <= r_wd_cnt + 13'd1;
    end
  end

  assign w_wd_hit = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                    (r_wd_cnt == WD_LAST);
`else
  assign w_wd_hit = 1'b0;
`endif

  // Next-state logic; a watchdog expiry overrides the engine handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_vld) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_wd_hit) begin
          w_state_nxt = S_RESP;
          w_abort     = 1'b1;
        end else if (i_eng_over) begin
          // a level already high on entry is taken as completion
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_wd_hit) begin
          w_state_nxt = S_RESP;
          w_abort     = 1'b1;
        end else if (!i_eng_over) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Job bookkeeping: grant id, operand, verdict capture and pointer update.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_id      <= '0;
      r_ptr     <= 3'(NREQ - 1);
      r_verdict <= 1'b0;
      o_eng_num <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_grant_vld) begin
        r_id      <= w_grant_id;
        o_eng_num <= w_grant_num;
      end
      if ((r_state == S_RUN) && i_eng_over && !w_abort) begin
        r_verdict <= i_eng_display;
      end
      if (r_state == S_RESP) begin
        r_ptr <= r_id;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_busy        <= 1'b0;
      o_eng_go      <= 1'b0;
      o_ack         <= '0;
      o_res_perfect <= 1'b0;
      o_res_err     <= 1'b0;
      o_res_id      <= '0;
    end else begin
      o_busy   <= (w_state_nxt != S_IDLE);
      o_eng_go <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
      o_ack    <= '0;
      if (w_state_nxt == S_RESP) begin
        o_ack         <= w_ack_nxt;
        o_res_id      <= r_id;
        o_res_perfect <= w_abort ? 1'b0 : r_verdict;
        o_res_err     <= w_abort;
      end
    end
  end

endmodule

// File: doc/perfect_sched.md
# perfect_sched

Round-robin scheduler that shares one perfect-number checker engine (the `FSM_controller` + datapath pair) between `NREQ` requesters. It arbitrates pending requests and drives the engine's `go`/`num` handshake through a full run-and-release cycle. It then returns the engine's verdict to the granted requester with a one-cycle acknowledge. It sits between the requester-side logic and the single engine instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 14: operand width; matches engine `num`.
- `TIMEOUT`, 4096: watchdog limit in cycles (used only when `PERFECT_SCHED_TIMEOUT_EN` is defined).

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request per requester; level.
- `req_num`  in  NREQ*W  operand of requester i at bits [i*W +: W].
- `ack`  out  NREQ  one-cycle completion pulse to requester i.
- `res_perfect`  out  1  verdict; valid while any `ack` bit is high.
- `res_err`  out  1  watchdog abort flag; valid with `ack`.
- `res_id`  out  3  index of the requester being acknowledged.
- `busy`  out  1  high in every state except IDLE.
- `eng_num`  out  W  operand to the engine `num` input.
- `eng_go`  out  1  to the engine `go` input.
- `eng_display`  in  1  engine verdict; 1 = perfect.
- `eng_over`  in  1  engine completion level.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP. Encoding is 3 bits.
- IDLE: if `req` is nonzero, grant the first set bit searching upward from `ptr+1` mod NREQ. Latch the grant id and its `req_num` into `eng_num`, then go to LOAD. Otherwise stay in IDLE.
- LOAD: `eng_go`=1, `eng_num` held; go to RUN.
- RUN: `eng_go`=1. When `eng_over`=1, capture `eng_display` into the result register and go to DRAIN.
- DRAIN: `eng_go`=0. When `eng_over`=0, go to RESP.
- RESP: `ack[id]`=1 and `res_id`=id; `res_perfect`/`res_err` driven from the result registers. Set `ptr`=id, then go to IDLE.
- `eng_num` is held constant from LOAD through RESP. It changes only on a grant.
- Requester rule: hold `req` and `req_num` stable until `ack`.
  - If `req` is still high in the cycle after `ack`, it is a new job.
  - Because `ptr` advanced, other pending requesters win first.
- Requester dropping `req` mid-job: the job still completes and `ack` still pulses. The result is discarded by the requester.
- An `eng_over` level that is already high on entry to RUN (stale) is accepted as completion. The engine holds `over` low while `go` is low, so DRAIN guarantees a clean start for the next job.
- Reset (asynchronous, any state):
  - state=IDLE, `ptr`=NREQ-1 (requester 0 first).
  - `eng_go`=0, `eng_num`=0, `ack`=0.
  - `res_perfect`=0, `res_err`=0, `res_id`=0, `busy`=0.
- After reset, the engine must also be reset by its own `rst`. The scheduler does not recover an engine left mid-run.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `req` rise in cycle t (state IDLE):
  - LOAD in t+1, `eng_go` high from t+1.
  - RUN from t+2.
- `eng_over` high in cycle u: DRAIN in u+1, `eng_go` low from u+1.
- `eng_over` low in cycle v: RESP in v+1, with `ack` high for exactly that cycle.
- Minimum req→ack latency is 4 cycles plus engine run time plus engine release time.
- Throughput: one job at a time; back-to-back grants are separated by the IDLE cycle.
- `ack` has at most one bit set. `res_*` are valid only while `ack` is nonzero and otherwise hold their last values.

## Configuration
- `PERFECT_SCHED_TIMEOUT_EN` defined:
  - A 13-bit (≥ clog2(TIMEOUT)) counter clears on LOAD and increments in RUN and DRAIN.
  - When it reaches TIMEOUT-1, force `eng_go`=0 and go to RESP with `res_err`=1 and `res_perfect`=0.
- Not defined: no counter. RUN and DRAIN wait indefinitely, and `res_err` is tied to 0.

## Test plan
- Single request: reset, `req`=0001, `req_num`[0]=28, engine model asserts `over` 30 cycles after `go` with `display`=1 → `ack`=0001 pulse, `res_perfect`=1, `res_id`=0, `res_err`=0.
- Non-perfect: `req`[2]=1, num=12, model `display`=0 → `ack`=0100, `res_perfect`=0, `res_id`=2.
- Fairness: all four `req` held high continuously → ack order 0,1,2,3,0,…; `eng_num` matches the granted operand at every LOAD.
- Handshake: `eng_over` held high 5 cycles after `eng_go` falls → `ack` appears exactly 1 cycle after `eng_over` falls; `eng_go` stays 0 during DRAIN.
- Reset mid-RUN: assert `rst`=0 asynchronously during RUN → `eng_go`, `busy`, `ack` read 0 immediately. After release, `req`=0010 with others pending is granted to requester 0 first if `req`[0] is set.
- Watchdog (macro defined, TIMEOUT=64): engine never asserts `over` → `ack` pulses 65 cycles after LOAD with `res_err`=1 and `res_perfect`=0. The next request is granted normally.
